bus_skid_buffer: RTL and testbench
==================================

Name: bus_skid_buffer

Overview:
- Two-entry skid buffer (full register slice) for the valid/ready bus.
- Sits directly downstream of bus_valid_delay and consumes its valid_o/data_o.
- Registers both the forward path (valid_o, data_o) and the backward path (ready_o), which breaks the combinational ready chain that bus_valid_delay leaves open.
- Sustains one transfer per cycle with no bubbles.

Parameters:
Width, 32, data bus width in bits

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  upstream data valid
ready_o  output  1  buffer can accept; registered
data_i  input  Width  upstream data
valid_o  output  1  downstream data valid; registered
ready_i  input  1  downstream can accept
data_o  output  Width  downstream data; registered (main register)
count_o  output  2  occupancy 0..2; registered

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high, named rst.
- Handshake definitions:
  - Input transfer: in_fire = valid_i & ready_o at a rising clk edge.
  - Output transfer: out_fire = valid_o & ready_i at a rising clk edge.
- Storage: main register (drives data_o) and skid register.
- States:
  - EMPTY (count 0)
  - BUSY (count 1, main valid)
  - FULL (count 2, main and skid valid)
- Combinational outputs from state: valid_o = (state != EMPTY); ready_o = (state != FULL) and not in post-reset hold; count_o = occupancy. All are driven from flops, with no combinational path from any input to any output.
- Transitions:
  - EMPTY, in_fire: main <= data_i; go to BUSY.
  - BUSY, in_fire & out_fire: main <= data_i; stay in BUSY.
  - BUSY, in_fire only: skid <= data_i; go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - FULL, out_fire: main <= skid; go to BUSY. in_fire is impossible because ready_o = 0.
  - FULL, no out_fire: hold.
- Latency: data accepted at edge N appears on data_o/valid_o after edge N (1 cycle) when the buffer was EMPTY, or after BUSY with a simultaneous out_fire.
- Ordering: strict FIFO; no drop, no duplication.
- Stall stability: while valid_o = 1 and ready_i = 0, data_o and valid_o hold unchanged.
- valid_i may deassert without a transfer; the buffer must not depend on upstream holding valid_i.
- Reset:
  - While rst = 1: state EMPTY, valid_o = 0, ready_o = 0, count_o = 0, data_o = 0, skid = 0.
  - First rising edge after rst deasserts: ready_o goes to 1 (one-cycle hold flop). No transfer can occur during reset.
- Reset mid-operation: asserting rst in BUSY/FULL immediately (asynchronously) clears valid_o and count_o. Buffered data is discarded.
- Throughput: with ready_i held 1, one transfer per cycle indefinitely and count_o never exceeds 1.
- With ready_i = 0: the buffer absorbs exactly 2 words, then ready_o = 0 on the cycle after the 2nd accept.
- Synthesizable, no latches, single clock domain.

Test Plan:
- Reset: hold rst = 1 with valid_i = 1 and data_i = 0xAA -> valid_o = 0, ready_o = 0, count_o = 0. After release, ready_o = 1 on the first edge and nothing is captured before that.
- Streaming: ready_i = 1, write 0x0..0xC back-to-back -> data_o shows 0x0..0xC in order, one per cycle, one cycle after each accept; ready_o stays 1; count_o <= 1.
- Fill/stall: ready_i = 0, write 0x1, 0x2, 0x3 -> 0x1 and 0x2 accepted, count_o = 2, ready_o = 0. 0x3 is held upstream. data_o = 0x1 is stable for the whole stall.
- Drain: from the FULL state above, raise ready_i -> outputs 0x1, 0x2, 0x3 on consecutive cycles; ready_o returns to 1 the cycle after 0x1 leaves.
- Alternating ready: ready_i toggles 1/0 every cycle (six ready cycles, then ready/idle pairs) while writing 0x0..0xC -> all 13 words received in order with no loss or duplication; data_o stable on every idle cycle.
- Mid-operation reset: in FULL with 0x5/0x6 buffered, pulse rst for 3 ns between edges -> valid_o and count_o drop to 0 immediately. After release, the next write 0x7 is the first word out.

Source files
------------

// File: rtl/bus_skid_buffer.sv
// Two-entry skid buffer for a valid/ready bus: forward and backward paths are both
// driven from flops, so the ready chain is broken while one transfer per cycle is kept.
module bus_skid_buffer #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    output logic [1:0]       count_o
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_p1;
    state_t           state_nxt;
    logic             ready_en_p1;
    logic [Width-1:0] main_p1;
    logic [Width-1:0] skid_p1;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign valid_o  = (state_p1 != EMPTY);
    assign ready_o  = (state_p1 != FULL) && ready_en_p1;
    assign count_o  = state_p1;
    assign data_o   = main_p1;

    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    always_comb begin
        state_nxt      = state_p1;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // ready_en_p1 keeps ready_o low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1    <= EMPTY;
            ready_en_p1 <= 1'b0;
        end else begin
            state_p1    <= state_nxt;
            ready_en_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_main_in) begin
                main_p1 <= data_i;
            end else if (load_main_skid) begin
                main_p1 <= skid_p1;
            end
            if (load_skid) begin
                skid_p1 <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_bus_skid_buffer.sv
// Directed bench for bus_skid_buffer: vector table for reset/stream/fill/drain plus
// hand-written sequences for alternating ready and mid-operation reset.
module tb_bus_skid_buffer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] data_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] data_o;
    logic [1:0]   count_o;

    int n_checks = 0;
    int n_pass   = 0;

    bus_skid_buffer #(.Width(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vi;
        logic         ri;
        logic [W-1:0] di;
        logic         ev;
        logic         er;
        logic [1:0]   ec;
        logic [W-1:0] ed;
        logic         cd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vi, input logic ri, input logic [W-1:0] di,
                       input logic ev, input logic er, input logic [1:0] ec,
                       input logic [W-1:0] ed, input logic cd);
        vec_t v;
        v.vi = vi; v.ri = ri; v.di = di;
        v.ev = ev; v.er = er; v.ec = ec; v.ed = ed; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic er,
                              input logic [1:0] ec, input logic [W-1:0] ed, input logic cd);
        check({tag, ".valid_o"}, W'(valid_o), W'(ev));
        check({tag, ".ready_o"}, W'(ready_o), W'(er));
        check({tag, ".count_o"}, W'(count_o), W'(ec));
        if (cd) check({tag, ".data_o"}, data_o, ed);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int sent;
    int rcv;
    logic fire_in;
    logic fire_out;
    logic stall;
    logic [W-1:0] held;

    initial begin
        // Streaming 0x0..0xC with ready_i = 1.
        for (int k = 0; k <= 12; k++) add(1'b1, 1'b1, W'(k), 1'b1, 1'b1, 2'd1, W'(k), 1'b1);
        add(1'b0, 1'b1, '0, 1'b0, 1'b1, 2'd0, W'(12), 1'b1);
        // Fill with ready_i = 0: 0x3 must be held off.
        add(1'b1, 1'b0, W'(1), 1'b1, 1'b1, 2'd1, W'(1), 1'b1);
        add(1'b1, 1'b0, W'(2), 1'b1, 1'b0, 2'd2, W'(1), 1'b1);
        add(1'b1, 1'b0, W'(3), 1'b1, 1'b0, 2'd2, W'(1), 1'b1);
        add(1'b1, 1'b0, W'(3), 1'b1, 1'b0, 2'd2, W'(1), 1'b1);
        add(1'b0, 1'b0, W'(3), 1'b1, 1'b0, 2'd2, W'(1), 1'b1);
        // Drain: 0x2 then 0x3 (0x3 accepted once ready_o returns).
        add(1'b1, 1'b1, W'(3), 1'b1, 1'b1, 2'd1, W'(2), 1'b1);
        add(1'b1, 1'b1, W'(3), 1'b1, 1'b1, 2'd1, W'(3), 1'b1);
        add(1'b0, 1'b1, '0, 1'b0, 1'b1, 2'd0, W'(3), 1'b1);

        // Reset held with upstream driving.
        rst = 1'b1; valid_i = 1'b1; data_i = 32'hAA; ready_i = 1'b1;
        repeat (2) tick();
        check_outs("reset", 1'b0, 1'b0, 2'd0, '0, 1'b1);
        rst = 1'b0;
        #1;
        check_outs("release_pre_edge", 1'b0, 1'b0, 2'd0, '0, 1'b1);
        tick();
        check_outs("release_first_edge", 1'b0, 1'b1, 2'd0, '0, 1'b1);
        valid_i = 1'b0;

        foreach (vecs[i]) begin
            valid_i = vecs[i].vi;
            ready_i = vecs[i].ri;
            data_i  = vecs[i].di;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ec,
                       vecs[i].ed, vecs[i].cd);
        end

        // Alternating ready: six ready cycles, then ready/idle pairs.
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 80 && rcv < 13; c++) begin
            valid_i = (sent < 13);
            data_i  = W'(sent);
            ready_i = (c < 6) ? 1'b1 : ((c - 6) % 2 == 0);
            #1;
            fire_in  = valid_i && ready_o;
            fire_out = valid_o && ready_i;
            stall    = valid_o && !ready_i;
            held     = data_o;
            if (fire_out) begin
                check($sformatf("alt_word%0d", rcv), data_o, W'(rcv));
                rcv++;
            end
            tick();
            if (fire_in) sent++;
            if (stall) begin
                check("alt_stall_valid", W'(valid_o), W'(1));
                check("alt_stall_data", data_o, held);
            end
        end
        check("alt_received", W'(rcv), W'(13));
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check_outs("alt_empty", 1'b0, 1'b1, 2'd0, '0, 1'b0);

        // Mid-operation reset while FULL with 0x5/0x6.
        ready_i = 1'b0; valid_i = 1'b1; data_i = W'(5);
        tick();
        data_i = W'(6);
        tick();
        valid_i = 1'b0;
        check_outs("midrst_full", 1'b1, 1'b0, 2'd2, W'(5), 1'b1);
        #2 rst = 1'b1;
        #1;
        check_outs("midrst_async", 1'b0, 1'b0, 2'd0, '0, 1'b1);
        #2 rst = 1'b0;
        ready_i = 1'b1; valid_i = 1'b1; data_i = W'(7);
        tick();
        check_outs("midrst_hold", 1'b0, 1'b1, 2'd0, '0, 1'b1);
        tick();
        valid_i = 1'b0;
        check_outs("midrst_first", 1'b1, 1'b1, 2'd1, W'(7), 1'b1);
        tick();
        check_outs("midrst_drain", 1'b0, 1'b1, 2'd0, W'(7), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
